// File: rtl/hilo_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl_if
// Purpose  : EX-stage <-> HI/LO multiply/divide unit connection bundle.
// Revision : 1.0  initial release
// ============================================================================
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output op_valid, op, rs_val, rt_val, mf_req,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val, mf_req,
    output hi, lo, busy, stall, done
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_ctrl
// Purpose  : HI/LO owner: iterative shift-add multiplier / restoring divider.
//            Optional macro HILO_FAST_MULT_EN: single-cycle multiply path.
// Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  hilo_muldiv_ctrl_if.slave   bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RUN     = 2'd1;
  localparam logic [1:0] c_FIX     = 2'd2;
  localparam logic [2:0] c_OP_MTHI = 3'b100;
  localparam logic [2:0] c_OP_MTLO = 3'b101;
  localparam logic [5:0] c_LAST    = 6'd31;

  logic [1:0]         r_state;
  logic [5:0]         r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_rs;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_p;
  logic               r_done;

  logic               w_signed;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_abs;
  logic [WIDTH-1:0]   w_rt_abs;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_trial;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // op[0] clear selects the signed variant of MULT/DIV
  assign w_signed = ~bus.op[0];
  assign w_rs_neg = w_signed & bus.rs_val[WIDTH-1];
  assign w_rt_neg = w_signed & bus.rt_val[WIDTH-1];
  assign w_rs_abs = w_rs_neg ? -bus.rs_val : bus.rs_val;
  assign w_rt_abs = w_rt_neg ? -bus.rt_val : bus.rt_val;

  // Multiply: r_p = {partial product, remaining multiplier bits}
  assign w_add      = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_p[0] ? r_opa : {WIDTH{1'b0}})};
  assign w_mul_next = {w_add, r_p[WIDTH-1:1]};

  // Divide: r_p = {partial remainder, dividend bits shifting into quotient}
  assign w_shift    = r_p[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_shift >= {1'b0, r_opa});
  assign w_trial    = w_shift[WIDTH-1:0] - r_opa;
  assign w_div_next = {(w_ge ? w_trial : w_shift[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};

  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_quot = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_rs_abs} * {{WIDTH{1'b0}}, w_rt_abs};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_cnt      <= 6'd0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_opa      <= {WIDTH{1'b0}};
      r_rs       <= {WIDTH{1'b0}};
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_p        <= {(2*WIDTH){1'b0}};
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (bus.op_valid) begin
            if (!bus.op[2]) begin
              r_is_div   <= bus.op[1];
              r_neg_q    <= w_rs_neg ^ w_rt_neg;
              r_neg_r    <= w_rs_neg;
              r_div_zero <= bus.op[1] & (bus.rt_val == {WIDTH{1'b0}});
              r_rs       <= bus.rs_val;
              r_cnt      <= 6'd0;
              if (bus.op[1]) begin
                r_opa   <= w_rt_abs;
                r_p     <= {{WIDTH{1'b0}}, w_rs_abs};
                r_state <= c_RUN;
              end else begin
`ifdef HILO_FAST_MULT_EN
                r_p     <= w_fast_prod;
                r_state <= c_FIX;
`else
                r_opa   <= w_rs_abs;
                r_p     <= {{WIDTH{1'b0}}, w_rt_abs};
                r_state <= c_RUN;
`endif
              end
            end else if (bus.op == c_OP_MTHI) begin
              r_hi <= bus.rs_val;
            end else if (bus.op == c_OP_MTLO) begin
              r_lo <= bus.rs_val;
            end
          end
        end
        c_RUN: begin
          r_p <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == c_LAST) begin
            r_state <= c_FIX;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        c_FIX: begin
          if (r_is_div) begin
            if (r_div_zero) begin
              r_hi <= r_rs;
              r_lo <= {WIDTH{1'b1}};
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_state <= c_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = (r_state != c_IDLE);
  assign bus.stall = bus.busy & (bus.op_valid | bus.mf_req);
  assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_ctrl
// Purpose  : Scoreboard bench: directed HI/LO mult/div/move vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;
  localparam int WIDTH = 32;
`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  hilo_muldiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no pulse", bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_hi", {32'd0, bus.hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, bus.lo}, {32'd0, e.lo});
        check("done_cycle", 64'(cyc), 64'(e.at));
        check("busy_in_done", {63'd0, bus.busy}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic push, input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    @(posedge clk);
    #1;
    if (push) begin
      exp_t e;
      e.hi = ehi;
      e.lo = elo;
      e.at = cyc + lat;
      exp_q.push_back(e);
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({"timeout_", name}, {63'd0, (n >= 100)}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    bus.op_valid = 1'b0;
    bus.op       = 3'b000;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.mf_req   = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hilo_in_reset", {bus.hi, bus.lo}, 64'd0);
    check("rst_flags_in_reset", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_flags", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);

    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    wait_idle("multu");
    // Each following op is issued in the done cycle of the previous one
    issue(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    wait_idle("mult");
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    wait_idle("div_neg");
    issue(3'b011, 32'h0000_0064, 32'd0, 1'b1, 32'h0000_0064, 32'hFFFF_FFFF, DIV_LAT);
    wait_idle("divu_zero");
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
    wait_idle("div_ovf");
    issue(3'b011, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, DIV_LAT);
    wait_idle("divu");
    issue(3'b010, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
    wait_idle("div_negdvsr");

    issue(3'b101, 32'h0000_ABCD, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    check("mtlo", {bus.hi, bus.lo}, {32'd1, 32'h0000_ABCD});
    check("mtlo_busy", {63'd0, bus.busy}, 64'd0);
    issue(3'b110, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'd0, 32'd0, 0);
    check("op110_ignored", {bus.hi, bus.lo}, {32'd1, 32'h0000_ABCD});
    check("op110_busy", {63'd0, bus.busy}, 64'd0);

    // MTHI and MFHI/MFLO held while a DIVU is in flight
    issue(3'b011, 32'd1000, 32'd10, 1'b1, 32'd0, 32'd100, DIV_LAT);
    bus.op_valid = 1'b1;
    bus.op       = 3'b100;
    bus.rs_val   = 32'h0000_1234;
    bus.mf_req   = 1'b1;
    @(negedge clk);
    begin
      int n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
        check("stall_while_busy", {63'd0, bus.stall}, 64'd1);
        check("hi_held_while_busy", {32'd0, bus.hi}, 64'd1);
        @(negedge clk);
        n++;
      end
      check("timeout_stall_div", {63'd0, (n >= 100)}, 64'd0);
    end
    check("stall_released", {63'd0, bus.stall}, 64'd0);
    check("mf_sees_new", {bus.hi, bus.lo}, {32'd0, 32'd100});
    @(posedge clk);
    #1;
    check("mthi_after_busy", {bus.hi, bus.lo}, {32'h0000_1234, 32'd100});
    check("mthi_no_busy", {63'd0, bus.busy}, 64'd0);
    bus.op_valid = 1'b0;
    bus.mf_req   = 1'b0;
    @(negedge clk);

    // Reset in the middle of a long operation discards the result
`ifdef HILO_FAST_MULT_EN
    issue(3'b011, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0, 0);
`else
    issue(3'b000, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0, 0);
`endif
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_reset", {63'd0, bus.busy}, 64'd1);
    bus.mf_req = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midop_reset_flags", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.mf_req = 1'b0;
    repeat (40) @(negedge clk);
    check("after_reset_idle", {bus.hi, bus.lo}, 64'd0);
    check("after_reset_busy", {63'd0, bus.busy}, 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
